// File: rtl/dword_readback_if.sv
// Byte-stream and PC-side bus of the dword readback path.
// Master drives the readout bytes, flush/clr and PC read strobe; slave is the packer/FIFO.
interface dword_readback_if #(
    parameter int unsigned DEPTH = 16
);
    logic                     byte_valid;
    logic [7:0]               byte_in;
    logic                     flush;
    logic                     clr;
    logic                     rd;
    logic [31:0]              data_to_PC;
    logic                     data_avail;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     busy;

    modport master (
        output byte_valid, byte_in, flush, clr, rd,
        input  data_to_PC, data_avail, level, overflow, busy
    );

    modport slave (
        input  byte_valid, byte_in, flush, clr, rd,
        output data_to_PC, data_avail, level, overflow, busy
    );
endinterface

// File: rtl/dword_readback.sv
// Packs readout bytes MSB-first into dwords and buffers them in a show-ahead FIFO for the PC.
// Optional trailer dword after each flush: define READBACK_TRAILER_EN.
module dword_readback #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk62,
    input  logic             RESET,
    dword_readback_if.slave  bus
);
    localparam int unsigned     AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = DEPTH[AW:0];

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] PAD     = 2'd1;
`ifdef READBACK_TRAILER_EN
    localparam logic [1:0] TRAILER = 2'd2;
`endif
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q, level_d;
    logic [31:0]      mem [DEPTH];

    logic             rst_all;
    logic             push;
    logic [31:0]      push_data;
    logic             pop;
    logic             full;
    logic             empty;
    logic             wr_en;

    assign rst_all = RESET | bus.clr;

`ifdef READBACK_TRAILER_EN
    logic [15:0] cnt16;
    assign cnt16 = 16'(cnt_q);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = acc_q;
        case (state_q)
            COLLECT: begin
                if (bus.byte_valid) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        push      = 1'b1;
                        push_data = {acc_q[31:8], bus.byte_in};
                        // Accumulator restarts at zero so a later pad needs no masking.
                        acc_d     = '0;
                    end else begin
                        acc_d[{~idx_q, 3'b000} +: 8] = bus.byte_in;
                    end
                end
                if (bus.flush) begin
                    if (idx_d != 2'd0) begin
                        state_d = PAD;
                    end else begin
`ifdef READBACK_TRAILER_EN
                        state_d = TRAILER;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            PAD: begin
                push  = 1'b1;
                acc_d = '0;
                idx_d = 2'd0;
`ifdef READBACK_TRAILER_EN
                state_d = TRAILER;
`else
                state_d = DONE;
`endif
            end
`ifdef READBACK_TRAILER_EN
            TRAILER: begin
                push      = 1'b1;
                push_data = {8'hE0, 7'b0, ovf_q, cnt16};
                state_d   = DONE;
            end
`endif
            DONE: begin
                cnt_d   = '0;
                state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign pop   = bus.rd & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign wr_en = push & (~full | pop);
    assign ovf_d = ovf_q | (push & full & ~pop);

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_en && pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk62) begin
        if (rst_all) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            level_q <= level_d;
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (pop)   rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk62) begin
        if (wr_en && !rst_all) begin
            mem[wptr_q] <= push_data;
        end
    end

    assign bus.data_to_PC = empty ? 32'h0 : mem[rptr_q];
    assign bus.data_avail = ~empty;
    assign bus.level      = level_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != COLLECT);
endmodule

// File: tb/tb_dword_readback.sv
// Randomised + directed bench for dword_readback with a byte-list reference model and scoreboard.
module tb_dword_readback;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 16;
`ifdef READBACK_TRAILER_EN
    localparam int TR_EN = 1;
`else
    localparam int TR_EN = 0;
`endif
    localparam int A_PAD  = 1;
    localparam int A_TRL  = 2;
    localparam int A_DONE = 3;

    logic clk62;
    logic RESET;

    dword_readback_if #(.DEPTH(DEPTH)) bus ();

    dword_readback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk62 (clk62),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        clk62 = 1'b0;
        forever #5 clk62 = ~clk62;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents, bytes of the current partial dword, pending flush actions.
    logic [31:0]      exp_q[$];
    logic [7:0]       bbuf[$];
    int               act_q[$];
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] b[$]);
        logic [31:0] d = 32'h0;
        for (int i = 0; i < b.size(); i++) d[31-8*i -: 8] = b[i];
        return d;
    endfunction

    task automatic model_push(input logic [31:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    // Model advances on the same edge as the DUT; pops were already taken by the monitor.
    initial forever begin
        int a;
        @(posedge clk62);
        if (RESET || bus.clr) begin
            exp_q.delete(); bbuf.delete(); act_q.delete();
            m_cnt = '0; m_ovf = 1'b0;
        end else if (act_q.size() == 0) begin
            if (bus.byte_valid) begin
                bbuf.push_back(bus.byte_in);
                m_cnt = m_cnt + 1'b1;
                if (bbuf.size() == 4) begin
                    model_push(pack(bbuf));
                    bbuf.delete();
                end
            end
            if (bus.flush) begin
                if (bbuf.size() != 0) act_q.push_back(A_PAD);
                if (TR_EN != 0) act_q.push_back(A_TRL);
                act_q.push_back(A_DONE);
            end
        end else begin
            a = act_q.pop_front();
            if (a == A_PAD) begin
                model_push(pack(bbuf));
                bbuf.delete();
            end else if (a == A_TRL) begin
                model_push({8'hE0, 7'b0, m_ovf, 16'(m_cnt)});
            end else begin
                m_cnt = '0;
            end
        end
    end

    // Monitor: compares outputs mid-cycle and pops the scoreboard on each accepted read.
    initial forever begin
        logic [31:0] d;
        @(negedge clk62);
        if (!RESET) begin
            chk("level", 32'(bus.level), 32'(exp_q.size()));
            chk("data_avail", 32'(bus.data_avail), 32'(exp_q.size() != 0));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("busy", 32'(bus.busy), 32'(act_q.size() != 0));
            if (exp_q.size() != 0) chk("head", bus.data_to_PC, exp_q[0]);
            if (bus.rd && exp_q.size() != 0) begin
                d = exp_q.pop_front();
                chk("pop_data", bus.data_to_PC, d);
            end
        end
    end

    task automatic step(input logic bv, input logic [7:0] b, input logic fl, input logic r,
                        input logic c);
        bus.byte_valid = bv; bus.byte_in = b; bus.flush = fl; bus.rd = r; bus.clr = c;
        @(posedge clk62);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while (bus.data_avail && guard < 4 * DEPTH) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        chk("drain_done", 32'(bus.data_avail), 32'd0);
        idle(1);
    endtask

    initial begin
        int nb;
        bus.byte_valid = 1'b0; bus.byte_in = 8'h00; bus.flush = 1'b0;
        bus.rd = 1'b0; bus.clr = 1'b0;
        RESET = 1'b1;
        idle(2);
        RESET = 1'b0;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_avail", 32'(bus.data_avail), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", bus.data_to_PC, 32'd0);

        // Bytes 01..08 then flush
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("t1_level", 32'(bus.level), 32'(2 + TR_EN));
        chk("t1_head", bus.data_to_PC, 32'h01020304);
        chk("t1_ovf", 32'(bus.overflow), 32'd0);
        drain();

        // Six bytes then flush: count busy cycles
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.busy) nb++;
            idle(1);
        end
        chk("t2_busy_cycles", 32'(nb), 32'(2 + TR_EN));
        chk("t2_head", bus.data_to_PC, 32'hAABBCCDD);
        drain();

        // Overflow: DEPTH+1 dwords with no reads
        for (int i = 0; i < 4 * (DEPTH + 1); i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t3_level", 32'(bus.level), 32'(DEPTH));
        chk("t3_ovf", 32'(bus.overflow), 32'd1);
        chk("t3_head", bus.data_to_PC, 32'h00010203);
        step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
        chk("t3_full_pushpop_level", 32'(bus.level), 32'(DEPTH));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t3_clr_ovf", 32'(bus.overflow), 32'd0);

        // Third byte with flush, then fourth byte with flush
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("t4_pad_level", 32'(bus.level), 32'(1 + TR_EN));
        chk("t4_pad_head", bus.data_to_PC, 32'h11223300);
        drain();
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("t4_full_level", 32'(bus.level), 32'(1 + TR_EN));
        chk("t4_full_head", bus.data_to_PC, 32'h44556677);
        drain();

        // clr while in PAD with two dwords stored
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("t5_in_pad_busy", 32'(bus.busy), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("t5_clr_level", 32'(bus.level), 32'd0);
        chk("t5_clr_avail", 32'(bus.data_avail), 32'd0);
        chk("t5_clr_busy", 32'(bus.busy), 32'd0);
        idle(3);
        chk("t5_no_push", 32'(bus.level), 32'd0);

        // Read when empty; then three dwords read back-to-back
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_rd_empty", 32'(bus.level), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("t6_level3", 32'(bus.level), 32'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_avail_before_last", 32'(bus.data_avail), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_avail_after", 32'(bus.data_avail), 32'd0);

        // Random traffic with varying read pressure
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 700; i++) begin
                step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 2 * ph + 1) == 0), 1'($urandom_range(0, 299) == 0));
            end
        end
        idle(4);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
